// File: rtl/conv7x7_sigmoid_core.sv
`timescale 1ns/1ps
// 7x7 convolution MAC (49 px x 49 Q8.8 weights + bias) followed by a piecewise-linear sigmoid.
// Latency: conv_out 9 cycles, sig_out 12+EXTRA_LAT cycles after en_in; one window per clock.
// No backpressure: en_in=0 only inserts a bubble. Define CONV_SAT_EN to saturate conv_out instead of wrapping.
module conv7x7_sigmoid_core #(
    parameter int EXTRA_LAT = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_in,
    input  logic [391:0] ima,
    input  logic [783:0] wei,
    input  logic [15:0]  bias,
    output logic         conv_valid,
    output logic [15:0]  conv_out,
    output logic         out_valid,
    output logic [15:0]  sig_out
);

    localparam int NVLD = 12 + EXTRA_LAT;
    localparam int NN   = 101;
    // Node storage: products at 0..48, then adder-tree levels packed back to back.
    localparam int LSZ  [0:6] = '{49, 25, 13, 7, 4, 2, 1};
    localparam int LOFF [0:6] = '{0, 49, 74, 87, 94, 98, 100};

    logic [NVLD:1]      vld_q, vld_d;
    logic [391:0]       ima_q, ima_d;
    logic [783:0]       wei_q, wei_d;
    logic signed [15:0] bias_q [1:8];
    logic signed [15:0] bias_d [1:8];
    logic signed [30:0] node_q [0:NN-1];
    logic signed [30:0] node_d [0:NN-1];
    logic signed [30:0] s9_sum;
    logic signed [15:0] conv_q, conv_d;
    logic [15:0]        abs_q, abs_d;
    logic               neg1_q, neg1_d;
    logic [8:0]         ypos_q, ypos_d;
    logic               neg2_q, neg2_d;
    logic signed [9:0]  y_signed;
    logic [8:0]         sig_q [0:EXTRA_LAT];
    logic [8:0]         sig_d [0:EXTRA_LAT];

    // Valid bit marches alongside the data; nothing ever stalls.
    always_comb begin
        vld_d = {vld_q[NVLD-1:1], en_in};
    end

    // S1 input capture and the bias delay line that meets the tree result at S9.
    always_comb begin
        ima_d     = en_in ? ima  : ima_q;
        wei_d     = en_in ? wei  : wei_q;
        bias_d    = bias_q;
        bias_d[1] = en_in ? bias : bias_q[1];
        for (int s = 2; s <= 8; s++) begin
            if (vld_q[s-1]) bias_d[s] = bias_q[s-1];
        end
    end

    // S2 products (pixel zero-extended to 9b signed) and S3..S8 pairwise adder tree.
    always_comb begin
        node_d = node_q;
        if (vld_q[1]) begin
            for (int k = 0; k < 49; k++) begin
                node_d[k] = 31'($signed({1'b0, ima_q[8*k +: 8]}) * $signed(wei_q[16*k +: 16]));
            end
        end
        for (int l = 1; l <= 6; l++) begin
            if (vld_q[l+1]) begin
                for (int i = 0; i < 25; i++) begin
                    if (i < LSZ[l]) begin
                        // An odd leftover node passes straight through to the next level.
                        if (2*i + 1 < LSZ[l-1])
                            node_d[LOFF[l]+i] = node_q[LOFF[l-1]+2*i] + node_q[LOFF[l-1]+2*i+1];
                        else
                            node_d[LOFF[l]+i] = node_q[LOFF[l-1]+2*i];
                    end
                end
            end
        end
    end

    // S9 bias add and narrowing to 16b; the register holds between strobes.
    always_comb begin
        s9_sum = node_q[NN-1] + 31'(bias_q[8]);
        conv_d = conv_q;
        if (vld_q[8]) begin
`ifdef CONV_SAT_EN
            if (s9_sum > 31'sd32767)
                conv_d = 16'sh7FFF;
            else if (s9_sum < -31'sd32768)
                conv_d = 16'sh8000;
            else
                conv_d = s9_sum[15:0];
`else
            conv_d = s9_sum[15:0];
`endif
        end
    end

    // Sigmoid stages: magnitude, segment evaluation, sign fold + clamp, then alignment delay.
    always_comb begin
        abs_d  = abs_q;
        neg1_d = neg1_q;
        ypos_d = ypos_q;
        neg2_d = neg2_q;
        sig_d  = sig_q;
        if (vld_q[9]) begin
            neg1_d = conv_q[15];
            // -32768 has no positive twin in 16b, so it maps to the largest magnitude.
            if (conv_q == 16'sh8000)
                abs_d = 16'h7FFF;
            else if (conv_q[15])
                abs_d = 16'(-conv_q);
            else
                abs_d = 16'(conv_q);
        end
        if (vld_q[10]) begin
            neg2_d = neg1_q;
            if (abs_q >= 16'h0500)
                ypos_d = 9'd256;
            else if (abs_q >= 16'h0260)
                ypos_d = 9'(abs_q >> 5) + 9'd216;
            else if (abs_q >= 16'h0100)
                ypos_d = 9'(abs_q >> 3) + 9'd160;
            else
                ypos_d = 9'(abs_q >> 2) + 9'd128;
        end
        y_signed = neg2_q ? (10'sd256 - $signed({1'b0, ypos_q})) : $signed({1'b0, ypos_q});
        if (vld_q[11]) begin
            if (y_signed < 10'sd0)
                sig_d[0] = 9'd0;
            else if (y_signed > 10'sd256)
                sig_d[0] = 9'd256;
            else
                sig_d[0] = y_signed[8:0];
        end
        for (int j = 1; j <= EXTRA_LAT; j++) begin
            if (vld_q[11+j]) sig_d[j] = sig_q[j-1];
        end
    end

    // State registers; async reset clears every valid bit and data word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            ima_q  <= '0;
            wei_q  <= '0;
            for (int s = 1; s <= 8; s++) bias_q[s] <= '0;
            for (int n = 0; n < NN; n++) node_q[n] <= '0;
            conv_q <= '0;
            abs_q  <= '0;
            neg1_q <= 1'b0;
            ypos_q <= '0;
            neg2_q <= 1'b0;
            for (int j = 0; j <= EXTRA_LAT; j++) sig_q[j] <= '0;
        end else begin
            vld_q  <= vld_d;
            ima_q  <= ima_d;
            wei_q  <= wei_d;
            bias_q <= bias_d;
            node_q <= node_d;
            conv_q <= conv_d;
            abs_q  <= abs_d;
            neg1_q <= neg1_d;
            ypos_q <= ypos_d;
            neg2_q <= neg2_d;
            sig_q  <= sig_d;
        end
    end

    assign conv_valid = vld_q[9];
    assign conv_out   = conv_q;
    assign out_valid  = vld_q[NVLD];
    assign sig_out    = {7'd0, sig_q[EXTRA_LAT]};

endmodule

// File: tb/tb_conv7x7_sigmoid_core.sv
`timescale 1ns/1ps
// Bench for conv7x7_sigmoid_core: scoreboard of expected conv/sigmoid values keyed by due cycle.
// Latency: checks conv at +9 and sigmoid at +18 after each en_in cycle.
// No backpressure on the DUT; the bench drives windows back-to-back or with random bubbles.
module tb_conv7x7_sigmoid_core;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en_in;
    logic [391:0] ima;
    logic [783:0] wei;
    logic [15:0]  bias;
    logic         conv_valid;
    logic [15:0]  conv_out;
    logic         out_valid;
    logic [15:0]  sig_out;

    conv7x7_sigmoid_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_in      (en_in),
        .ima        (ima),
        .wei        (wei),
        .bias       (bias),
        .conv_valid (conv_valid),
        .conv_out   (conv_out),
        .out_valid  (out_valid),
        .sig_out    (sig_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int cdue[$], cval[$], sdue[$], sval[$];
    logic [15:0] last_conv = '0;
    logic [15:0] last_sig  = '0;
    int pix [49];
    int w   [49];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int conv_model(input int b);
        longint s;
        s = b;
        for (int k = 0; k < 49; k++) s += longint'(pix[k]) * w[k];
`ifdef CONV_SAT_EN
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
`endif
        return int'(s & 64'hFFFF);
    endfunction

    function automatic int sig_model(input int c16);
        int x, a, y;
        x = (c16 >= 32768) ? c16 - 65536 : c16;
        a = (x < 0) ? -x : x;
        if (a > 32767) a = 32767;
        if (a >= 1280)     y = 256;
        else if (a >= 608) y = a / 32 + 216;
        else if (a >= 256) y = a / 8 + 160;
        else               y = a / 4 + 128;
        if (x < 0) y = 256 - y;
        if (y < 0)   y = 0;
        if (y > 256) y = 256;
        return y;
    endfunction

    task automatic set_all(input int p, input int wv);
        for (int k = 0; k < 49; k++) begin
            pix[k] = p;
            w[k]   = wv;
        end
    endtask

    task automatic send(input int b, input int ec, input int es);
        @(posedge clk);
        #1;
        for (int k = 0; k < 49; k++) begin
            ima[8*k +: 8]  = pix[k][7:0];
            wei[16*k +: 16] = w[k][15:0];
        end
        bias  = b[15:0];
        en_in = 1'b1;
        cdue.push_back(cyc + 9);
        cval.push_back(ec);
        sdue.push_back(cyc + 18);
        sval.push_back(es);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            en_in = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((cdue.size() + sdue.size()) != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check("drain", cdue.size() + sdue.size(), 0);
    endtask

    // Scoreboard monitor, sampling away from the rising edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            automatic logic cexp = (cdue.size() > 0) && (cdue[0] == cyc);
            automatic logic sexp = (sdue.size() > 0) && (sdue[0] == cyc);
            if (conv_valid || cexp) begin
                check("conv_valid", conv_valid, cexp);
                if (cexp) begin
                    if (conv_valid) check("conv_out", conv_out, cval[0]);
                    last_conv = cval[0][15:0];
                    void'(cdue.pop_front());
                    void'(cval.pop_front());
                end else begin
                    last_conv = conv_out;
                end
            end else begin
                check("conv_hold", conv_out, last_conv);
            end
            if (out_valid || sexp) begin
                check("out_valid", out_valid, sexp);
                if (sexp) begin
                    if (out_valid) check("sig_out", sig_out, sval[0]);
                    last_sig = sval[0][15:0];
                    void'(sdue.pop_front());
                    void'(sval.pop_front());
                end else begin
                    last_sig = sig_out;
                end
            end else begin
                check("sig_hold", sig_out, last_sig);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b, ec;
        rst_n = 1'b0;
        en_in = 1'b0;
        ima   = '0;
        wei   = '0;
        bias  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_conv_valid", conv_valid, 0);
        check("rst_conv_out", conv_out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_sig_out", sig_out, 0);
        rst_n = 1'b1;
        idle(2);

        // Zero weights, bias 1.0: single isolated strobe pair.
        for (int k = 0; k < 49; k++) begin
            pix[k] = $urandom_range(0, 255);
            w[k]   = 0;
        end
        send(32'h0100, 32'h0100, 32'h00C0);
        idle(25);

        // Unit pixels, weight 1.0.
        set_all(1, 32'h0100);
        send(0, 32'h3100, 32'h0100);
        idle(20);

        // Centre pixel only, weight -1.0.
        set_all(0, -256);
        pix[24] = 2;
        send(0, 32'hFE00, 32'h0020);
        idle(20);

        // Overflowing sum: wrap or saturate depending on build.
        set_all(255, 32'h7FFF);
`ifdef CONV_SAT_EN
        send(0, 32'h7FFF, 32'h0100);
`else
        send(0, 32'h4F31, 32'h0100);
`endif
        idle(20);

        // Three consecutive windows: strobes on +18..+20 with no gaps.
        set_all(0, 0);
        send(32'h0000, 32'h0000, 32'h0080);
        send(32'hFF00, 32'hFF00, 32'h0040);
        send(32'h0260, 32'h0260, 32'h00EB);
        idle(25);

        // Random windows, mixing small weights (all sigmoid segments) and full-range ones.
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < 49; k++) begin
                pix[k] = $urandom_range(0, 255);
                if (n % 2 == 1) w[k] = int'($urandom_range(0, 4)) - 2;
                else            w[k] = int'($urandom_range(0, 65535)) - 32768;
            end
            b  = int'($urandom_range(0, 65535)) - 32768;
            ec = conv_model(b);
            send(b, ec, sig_model(ec));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(1);
        drain();

        // Reset five cycles into flight: that window must never emerge.
        set_all(1, 32'h0100);
        send(0, 32'h3100, 32'h0100);
        idle(5);
        rst_n = 1'b0;
        cdue.delete();
        cval.delete();
        sdue.delete();
        sval.delete();
        last_conv = '0;
        last_sig  = '0;
        #1;
        check("flush_conv_valid", conv_valid, 0);
        check("flush_conv_out", conv_out, 0);
        check("flush_out_valid", out_valid, 0);
        check("flush_sig_out", sig_out, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(30);

        // Recovery after reset.
        for (int k = 0; k < 49; k++) begin
            pix[k] = $urandom_range(0, 255);
            w[k]   = int'($urandom_range(0, 4)) - 2;
        end
        ec = conv_model(32'h0040);
        send(32'h0040, ec, sig_model(ec));
        idle(1);
        drain();
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
